security_lock_controller: RTL
=============================

# security_lock_controller

Top-level sequencer for the security device. Sits downstream of the keypad controller, consuming its 16-bit entered-code bus, `storageFull` flag and `enter`/`newPassword` pulses. Holds the stored access code and decides lock/unlock. Drives a clear request back to the digit store, plus a timed unlock output and a failed-attempt lockout alarm.

## Interface
- `MAX_ATTEMPTS`, 3: consecutive wrong codes that trigger lockout; range 1..15.
- `UNLOCK_CYCLES`, 500_000_000: cycles `unlocked` stays high; also the SET_NEW timeout; must be ≥2.
- `LOCKOUT_CYCLES`, 1_000_000_000: cycles spent in LOCKOUT; must be ≥2.
- `DEFAULT_CODE`, 16'h1234: code loaded at reset; 4 BCD nibbles, most significant = first digit.
- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `digits`  in  16  entered code from the keypad controller.
- `storageFull`  in  1  high when 4 digits have been entered.
- `enter`  in  1  one-cycle pulse, E key.
- `newPassword`  in  1  one-cycle pulse, A key.
- `clearEntry`  out  1  one-cycle pulse that clears the digit store.
- `unlocked`  out  1  lock actuator; high in UNLOCKED and SET_NEW.
- `alarm`  out  1  high in LOCKOUT.
- `setMode`  out  1  high in SET_NEW.
- `failCount`  out  4  current consecutive wrong-code count.

## Operation
- Internal registers:
  - `state`: LOCKED, UNLOCKED, SET_NEW or LOCKOUT.
  - `code[15:0]`.
  - `failCount[3:0]`.
  - `timer`: wide enough for max(`UNLOCK_CYCLES`, `LOCKOUT_CYCLES`).
- Reset values: state=LOCKED, code=`DEFAULT_CODE`, failCount=0, timer=0. All outputs are 0 during and after reset.
- "Accepted enter": an `enter` pulse in any state except LOCKOUT. Every accepted enter produces a `clearEntry` pulse.
- LOCKED:
  - enter && storageFull && digits==code → UNLOCKED; timer=`UNLOCK_CYCLES`-1; failCount=0.
  - enter && storageFull && digits!=code → failCount+1.
    - If the new count equals `MAX_ATTEMPTS` → LOCKOUT; timer=`LOCKOUT_CYCLES`-1.
    - Otherwise stay LOCKED.
  - enter && !storageFull → stay; failCount unchanged (partial entry discarded via clearEntry).
  - newPassword → ignored.
- UNLOCKED:
  - timer decrements each cycle.
  - timer==0 → LOCKED, with a clearEntry pulse.
  - enter → LOCKED (manual relock).
  - newPassword → SET_NEW; timer=`UNLOCK_CYCLES`-1; clearEntry pulse.
- SET_NEW:
  - timer decrements each cycle.
  - enter && storageFull → code=digits; go LOCKED.
  - enter && !storageFull → stay; timer not reloaded.
  - newPassword → abort to UNLOCKED; timer=`UNLOCK_CYCLES`-1; code unchanged; clearEntry pulse.
  - timer==0 → LOCKED; code unchanged; clearEntry pulse.
- LOCKOUT:
  - `enter` and `newPassword` are ignored; no clearEntry on keys.
  - timer==0 → LOCKED; failCount=0; clearEntry pulse.
- Simultaneous events, in priority order:
  - reset over everything.
  - enter over newPassword.
  - In UNLOCKED/SET_NEW, a key event in the same cycle as timer==0 wins over timer expiry.
- `digits` values are compared as raw 16 bits; no BCD validity check.

## Timing
- Inputs are sampled on the rising edge where `enter`/`newPassword` is high (edge N).
- `state`, `code`, `failCount` and all level outputs update at edge N; they are visible in the cycle after.
- `clearEntry` is registered. It is high for exactly the cycle following edge N, then low.
- UNLOCKED entered without interruption: `unlocked` is high for exactly `UNLOCK_CYCLES` cycles. The same rule applies to `alarm` and `LOCKOUT_CYCLES`.
- No input is registered before use. The upstream pulses are already synchronous to `clk`.
- Reset asserted mid-operation: state, code and counters return to reset values immediately (asynchronously), and any in-flight clearEntry is dropped. A changed code is lost.

## Configuration
- Macro: `SECURITY_LOCK_LOCKOUT_EN`.
- Defined:
  - failCount and LOCKOUT behave as described above.
- Undefined:
  - LOCKOUT is unreachable.
  - A wrong code only produces clearEntry and stays in LOCKED.
  - `failCount` is tied to 0 and `alarm` is tied to 0.
  - `LOCKOUT_CYCLES` is unused.

## Test plan
Use `UNLOCK_CYCLES`=8, `LOCKOUT_CYCLES`=16, `MAX_ATTEMPTS`=3, and the macro defined unless noted.
- Reset, then digits=16'h1234, storageFull=1, enter pulse → unlocked=1 the next cycle for exactly 8 cycles, then 0; clearEntry pulses after the enter and again at expiry.
- Three enters with digits=16'h1111 and storageFull=1 → failCount 1, 2, then alarm=1 for 16 cycles. Enter during the alarm causes no state change and no clearEntry. Afterwards failCount=0, state LOCKED.
- Unlock with 1234; newPassword → setMode=1. Enter digits=16'h9876 → LOCKED. Enter 1234 → stays locked, failCount=1. Enter 9876 → unlocked=1.
- In SET_NEW, apply no keys for 8 cycles → LOCKED with code still 16'h1234. Also in SET_NEW, enter with storageFull=0 → stays in SET_NEW with a clearEntry pulse.
- Assert reset low mid-UNLOCKED after a code change → unlocked=0 immediately, and code reverts to 16'h1234.
- Macro undefined: five wrong enters → alarm stays 0, failCount stays 0, and the correct code still unlocks.

Source files
------------

// File: rtl/security_lock_controller.sv
// Lock sequencer: holds the access code, times the unlock window and the lockout alarm.
// Optional failed-attempt lockout is enabled by defining SECURITY_LOCK_LOCKOUT_EN.
module security_lock_controller #(
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned UNLOCK_CYCLES  = 500_000_000,
    parameter int unsigned LOCKOUT_CYCLES = 1_000_000_000,
    parameter logic [15:0] DEFAULT_CODE   = 16'h1234
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic        storageFull,
    input  logic        enter,
    input  logic        newPassword,
    output logic        clearEntry,
    output logic        unlocked,
    output logic        alarm,
    output logic        setMode,
    output logic [3:0]  failCount
);

    localparam int unsigned TIMER_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int unsigned TW        = $clog2(TIMER_MAX);
    localparam logic [TW-1:0] UNLOCK_RELOAD = TW'(UNLOCK_CYCLES - 1);

    localparam logic [1:0] ST_LOCKED   = 2'd0;
    localparam logic [1:0] ST_UNLOCKED = 2'd1;
    localparam logic [1:0] ST_SET_NEW  = 2'd2;
`ifdef SECURITY_LOCK_LOCKOUT_EN
    localparam logic [1:0] ST_LOCKOUT  = 2'd3;
    localparam logic [TW-1:0] LOCKOUT_RELOAD = TW'(LOCKOUT_CYCLES - 1);
`endif

    if (MAX_ATTEMPTS < 1 || MAX_ATTEMPTS > 15 || UNLOCK_CYCLES < 2 || LOCKOUT_CYCLES < 2) begin : g_bad_params
        $error("security_lock_controller: parameter out of range");
    end

    logic [1:0]    state;
    logic [15:0]   code;
    logic [TW-1:0] timer;
`ifdef SECURITY_LOCK_LOCKOUT_EN
    logic [3:0]    fail_cnt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_LOCKED;
            code       <= DEFAULT_CODE;
            timer      <= '0;
            clearEntry <= 1'b0;
`ifdef SECURITY_LOCK_LOCKOUT_EN
            fail_cnt   <= '0;
`endif
        end else begin
            clearEntry <= 1'b0;
            case (state)
                ST_LOCKED: begin
                    if (enter) begin
                        clearEntry <= 1'b1;
                        if (storageFull && digits == code) begin
                            state <= ST_UNLOCKED;
                            timer <= UNLOCK_RELOAD;
`ifdef SECURITY_LOCK_LOCKOUT_EN
                            fail_cnt <= '0;
                        end else if (storageFull) begin
                            fail_cnt <= fail_cnt + 4'd1;
                            if (fail_cnt + 4'd1 == 4'(MAX_ATTEMPTS)) begin
                                state <= ST_LOCKOUT;
                                timer <= LOCKOUT_RELOAD;
                            end
`endif
                        end
                    end
                end
                ST_UNLOCKED: begin
                    if (enter) begin
                        state      <= ST_LOCKED;
                        clearEntry <= 1'b1;
                    end else if (newPassword) begin
                        state      <= ST_SET_NEW;
                        timer      <= UNLOCK_RELOAD;
                        clearEntry <= 1'b1;
                    end else if (timer == '0) begin
                        state      <= ST_LOCKED;
                        clearEntry <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_SET_NEW: begin
                    if (enter) begin
                        clearEntry <= 1'b1;
                        if (storageFull) begin
                            code  <= digits;
                            state <= ST_LOCKED;
                        end else if (timer != '0) begin
                            // a partial entry landing on expiry holds the timer at zero; expiry follows next cycle
                            timer <= timer - 1'b1;
                        end
                    end else if (newPassword) begin
                        state      <= ST_UNLOCKED;
                        timer      <= UNLOCK_RELOAD;
                        clearEntry <= 1'b1;
                    end else if (timer == '0) begin
                        state      <= ST_LOCKED;
                        clearEntry <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
`ifdef SECURITY_LOCK_LOCKOUT_EN
                ST_LOCKOUT: begin
                    if (timer == '0) begin
                        state      <= ST_LOCKED;
                        fail_cnt   <= '0;
                        clearEntry <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
`endif
                default: state <= ST_LOCKED;
            endcase
        end
    end

    always_comb begin
        unlocked = (state == ST_UNLOCKED) || (state == ST_SET_NEW);
        setMode  = (state == ST_SET_NEW);
`ifdef SECURITY_LOCK_LOCKOUT_EN
        alarm     = (state == ST_LOCKOUT);
        failCount = fail_cnt;
`else
        alarm     = 1'b0;
        failCount = '0;
`endif
    end

endmodule
